// File: rtl/fetch_stage.sv
// Fetch stage: PC register, combinational imem port, FWFT fetch buffer.
// Branch redirect flushes the buffer and reloads an aligned PC.
module fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         BranchTaken,
  input  logic [ADDR_WIDTH-1:0]        BranchTarget,
  input  logic                         OutReady,
  output logic [ADDR_WIDTH-1:0]        ImemAddr,
  input  logic [INST_WIDTH-1:0]        ImemData,
  output logic                         OutValid,
  output logic [INST_WIDTH-1:0]        OutInst,
  output logic [ADDR_WIDTH-1:0]        OutPCAdd4,
  output logic [$clog2(DEPTH+1)-1:0]   Level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SH = $clog2(PC_STEP);

  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ONE =
    ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] MASK =
    ~((ONE << SH) - ONE);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pcn;
  } entry_t;

  entry_t                fifo_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [PW-1:0]         rd_q;
  logic [PW-1:0]         wr_q;
  logic [LW-1:0]         lvl_q;
  logic                  empty;
  logic                  push;
  logic                  pop;
  entry_t                head;

  assign pc_inc   = pc_q + STEP;
  assign ImemAddr = pc_q;
  assign empty    = (lvl_q == '0);
  assign OutValid = ~empty;
  assign Level    = lvl_q;

  assign pop  = OutValid & OutReady & ~BranchTaken;
  assign push = ((lvl_q < FULL) | pop) & ~BranchTaken;

  assign head      = fifo_q[rd_q];
  assign OutInst   = empty ? '0 : head.inst;
  assign OutPCAdd4 = empty ? '0 : head.pcn;

  // PC, pointers and occupancy; reset beats redirect beats fetch
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q  <= RESET_PC;
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else if (BranchTaken) begin
      pc_q  <= BranchTarget & MASK;
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) begin
        pc_q <= pc_inc;
        wr_q <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   lvl_q <= lvl_q + LW'(1);
        2'b01:   lvl_q <= lvl_q - LW'(1);
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  // Buffer storage; contents past the head are masked by the level
  always_ff @(posedge Clk) begin
    if (!Rst && push) begin
      fifo_q[wr_q] <= '{inst: ImemData, pcn: pc_inc};
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every
// cycle, directed literal scenarios, randomized redirects and stalls.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        OutReady;
  logic [31:0] ImemAddr;
  logic [31:0] ImemData;
  logic        OutValid;
  logic [31:0] OutInst;
  logic [31:0] OutPCAdd4;
  logic [2:0]  Level;

  logic        rst2;
  logic        br2;
  logic [31:0] tgt2;
  logic        rdy2;
  logic [31:0] ImemAddr2;
  logic [31:0] ImemData2;
  logic        OutValid2;
  logic [31:0] OutInst2;
  logic [31:0] OutPCAdd42;
  logic [2:0]  Level2;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [63:0] mq [$];
  logic [31:0] mpc;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign ImemData  = memf(ImemAddr);
  assign ImemData2 = memf(ImemAddr2);

  fetch_stage dut (
    .Clk(Clk), .Rst(Rst),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .OutReady(OutReady), .ImemAddr(ImemAddr),
    .ImemData(ImemData), .OutValid(OutValid),
    .OutInst(OutInst), .OutPCAdd4(OutPCAdd4),
    .Level(Level)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .Clk(Clk), .Rst(rst2),
    .BranchTaken(br2), .BranchTarget(tgt2),
    .OutReady(rdy2), .ImemAddr(ImemAddr2),
    .ImemData(ImemData2), .OutValid(OutValid2),
    .OutInst(OutInst2), .OutPCAdd4(OutPCAdd42),
    .Level(Level2)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: in-order queue of {inst, pc+4}
  always @(posedge Clk) begin
    bit do_pop;
    bit do_push;
    if (Rst) begin
      mq.delete();
      mpc = 32'h0;
    end else if (BranchTaken) begin
      mq.delete();
      mpc = BranchTarget & ~32'h3;
    end else begin
      do_pop  = (mq.size() > 0) && OutReady;
      do_push = (mq.size() < 4) || do_pop;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({memf(mpc), mpc + 32'd4});
        mpc = mpc + 32'd4;
      end
    end
  end

  // Compare DUT against model mid-cycle
  always @(negedge Clk) begin
    logic [63:0] hd;
    if (chk_en) begin
      hd = (mq.size() > 0) ? mq[0] : 64'h0;
      chk("m_addr", ImemAddr, mpc);
      chk("m_level", {29'b0, Level}, mq.size());
      chk("m_valid", {31'b0, OutValid},
          {31'b0, mq.size() > 0});
      chk("m_inst", OutInst, hd[63:32]);
      chk("m_pcadd4", OutPCAdd4, hd[31:0]);
    end
  end

  task automatic cyc(input logic r, input logic b,
                     input logic [31:0] t,
                     input logic rd);
    Rst          = r;
    BranchTaken  = b;
    BranchTarget = t;
    OutReady     = rd;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int exp_lv [6];
    exp_lv = '{1, 2, 3, 4, 4, 4};
    rst2 = 1'b1;
    br2  = 1'b0;
    tgt2 = 32'h0;
    rdy2 = 1'b0;

    // reset and fill with decode stalled
    cyc(1, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0);
    chk("rst_level", {29'b0, Level}, 0);
    chk("rst_valid", {31'b0, OutValid}, 0);
    chk("rst_inst", OutInst, 0);
    chk("rst_pcadd4", OutPCAdd4, 0);
    chk("rst_addr", ImemAddr, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0);
      chk($sformatf("fill_lv%0d", i),
          {29'b0, Level}, exp_lv[i]);
    end
    chk("fill_addr", ImemAddr, 32'h10);
    chk("fill_inst", OutInst, 32'h1000_0000);
    chk("fill_pcadd4", OutPCAdd4, 32'h4);

    // pop and push together while full
    cyc(0, 0, 0, 1);
    chk("full_pp_level", {29'b0, Level}, 4);
    chk("full_pp_head", OutPCAdd4, 32'h8);
    chk("full_pp_addr", ImemAddr, 32'h14);

    // redirect at level 3 with misaligned target
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("pre_br_level", {29'b0, Level}, 3);
    cyc(0, 1, 32'h43, 0);
    chk("br_level", {29'b0, Level}, 0);
    chk("br_valid", {31'b0, OutValid}, 0);
    chk("br_addr", ImemAddr, 32'h40);
    cyc(0, 0, 0, 0);
    chk("br_inst", OutInst, 32'h1000_0010);
    chk("br_pcadd4", OutPCAdd4, 32'h44);

    // reset beats redirect
    cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 1, 32'h80, 0);
    chk("rb_addr", ImemAddr, 32'h0);
    chk("rb_level", {29'b0, Level}, 0);
    chk("rb_valid", {31'b0, OutValid}, 0);
    chk("rb_inst", OutInst, 0);

    // streaming with decode always ready
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 0, 1);
      chk($sformatf("str_pc%0d", k),
          OutPCAdd4, 32'(4 * k));
      chk($sformatf("str_lv%0d", k),
          {29'b0, Level}, 1);
    end

    // empty with ready has no effect
    cyc(0, 1, 32'h200, 1);
    cyc(0, 1, 32'h300, 1);
    chk("empty_rdy_lv", {29'b0, Level}, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic        r;
      logic        b;
      logic [31:0] t;
      logic        rd;
      r  = ($urandom_range(0, 99) < 2);
      b  = ($urandom_range(0, 9) == 0);
      t  = $urandom;
      if ($urandom_range(0, 3) == 0)
        t = 32'hFFFF_FFE0 | (t & 32'h1F);
      rd = ($urandom_range(0, 2) != 0);
      if (n % 200 > 170) rd = 1'b0;
      cyc(r, b, t, rd);
    end

    // wrap-around from a top-of-memory reset PC
    chk_en = 1'b0;
    cyc(0, 0, 0, 0);
    chk("w_rst_addr", ImemAddr2, 32'hFFFF_FFFC);
    rst2 = 1'b0;
    cyc(0, 0, 0, 0);
    chk("w_level", {29'b0, Level2}, 1);
    chk("w_pcadd4", OutPCAdd42, 32'h0);
    chk("w_inst", OutInst2, 32'h4FFF_FFFF);
    chk("w_addr", ImemAddr2, 32'h0);
    cyc(0, 0, 0, 0);
    chk("w_addr2", ImemAddr2, 32'h4);
    chk("w_level2", {29'b0, Level2}, 2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
